// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction applied when the result is written.
module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         z_flag
);

   // state  | meaning
   // IDLE   | waiting for start; operands latched on acceptance
   // CALC   | one multiply/divide iteration per cycle, N cycles
   // DONE   | result valid for one cycle, then back to IDLE
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam int CW = $clog2(N) + 1;

   logic [1:0]     r_state;
   logic [2:0]     r_op;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_b;
   logic           r_neg;
   logic [CW-1:0]  r_cnt;
   logic [2*N-1:0] r_acc;
   logic [N-1:0]   r_result;

   logic           w_a_sgn;
   logic           w_b_sgn;
   logic           w_a_neg;
   logic           w_b_neg;
   logic [N-1:0]   w_a_mag;
   logic [N-1:0]   w_b_mag;
   logic           w_neg;
   logic           w_div0;
   logic           w_ovf;
   logic [N-1:0]   w_special_res;

   assign w_a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
   assign w_b_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign w_a_neg = w_a_sgn & op_a[N-1];
   assign w_b_neg = w_b_sgn & op_b[N-1];
   assign w_a_mag = w_a_neg ? (~op_a + 1'b1) : op_a;
   assign w_b_mag = w_b_neg ? (~op_b + 1'b1) : op_b;
   // A remainder follows the dividend's sign; everything else follows the sign product.
   assign w_neg   = (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

   assign w_div0 = op[2] && (op_b == '0);
   assign w_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                   (op_a == {1'b1, {(N-1){1'b0}}}) && (op_b == '1);
   always_comb begin
      w_special_res = '0;
      if (w_div0)
         w_special_res = op[1] ? op_a : '1;
      else if (w_ovf)
         w_special_res = op[1] ? '0 : op_a;
   end

   // Multiply: accumulator holds {partial product, remaining multiplier bits}.
   logic [N:0]     w_mul_sum;
   logic [2*N-1:0] w_mul_nxt;
   assign w_mul_sum = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_a} : {(N+1){1'b0}});
   assign w_mul_nxt = {w_mul_sum, r_acc[N-1:1]};

   // Divide: accumulator holds {partial remainder, dividend bits shifting into quotient}.
   logic [N:0]     w_rem_sh;
   logic           w_ge;
   logic [N-1:0]   w_rem_sub;
   logic [N-1:0]   w_rem_new;
   logic [2*N-1:0] w_div_nxt;
   assign w_rem_sh  = r_acc[2*N-1:N-1];
   assign w_ge      = (w_rem_sh >= {1'b0, r_b});
   assign w_rem_sub = w_rem_sh[N-1:0] - r_b;
   assign w_rem_new = w_ge ? w_rem_sub : w_rem_sh[N-1:0];
   assign w_div_nxt = {w_rem_new, r_acc[N-2:0], w_ge};

   logic [2*N-1:0] w_acc_nxt;
   logic [2*N-1:0] w_prod;
   logic [N-1:0]   w_div_val;
   logic [N-1:0]   w_div_fix;
   logic [N-1:0]   w_final;
   assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
   assign w_prod    = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
   assign w_div_val = r_op[1] ? w_acc_nxt[2*N-1:N] : w_acc_nxt[N-1:0];
   assign w_div_fix = r_neg ? (~w_div_val + 1'b1) : w_div_val;
   assign w_final   = r_op[2] ? w_div_fix :
                      ((r_op == OP_MUL) ? w_prod[N-1:0] : w_prod[2*N-1:N]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op  <= op;
                  r_a   <= w_a_mag;
                  r_b   <= w_b_mag;
                  r_neg <= w_neg;
                  if (w_div0 || w_ovf) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_acc   <= op[2] ? {{N{1'b0}}, w_a_mag} : {{N{1'b0}}, w_b_mag};
                     r_cnt   <= CW'(N);
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_result <= w_final;
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign z_flag = (r_result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (N=32): hand-computed results, latency, busy/done
// behaviour, ignored restarts, input changes after acceptance and reset abort.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        z_flag;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.N(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .z_flag(z_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at #1 after an edge with the DUT idle; returns at #1 after an edge in the
   // idle cycle that follows DONE, so calls chain back-to-back.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int          lat;
      logic        busy_ok;
      logic        held_ok;
      logic [31:0] prev;
      prev    = result;
      busy_ok = 1'b1;
      held_ok = 1'b1;
      op = o; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      op = ~o; op_a = ~a; op_b = b ^ 32'h5; start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (result !== prev) held_ok = 1'b0;
         start = (lat == 10);
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check({tag, "_result"}, result, exp);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_at_done"}, busy, 1'b1);
      check({tag, "_busy_during"}, busy_ok, 1'b1);
      check({tag, "_result_held"}, held_ok, 1'b1);
      @(posedge clk); #1;
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_done"}, done, 1'b0);
   endtask

   initial begin
      int   seen_done;
      rst = 1'b1; start = 1'b1; op = 3'b000; op_a = 32'd3; op_b = 32'd3;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_result", result, 32'h0);
      check("reset_zflag", z_flag, 1'b1);

      run_op("mul_7xm3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      check("mul_zflag", z_flag, 1'b0);
      run_op("mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("mulhsu_max",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("mul_m1xm1",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
      run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        33);
      run_op("divu_by0",    3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1);
      run_op("remu_by0",    3'b111, 32'h1234,     32'h0,        32'h00001234, 1);
      run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      check("rem_ovf_zflag", z_flag, 1'b1);

      run_op("mul_3x5",     3'b000, 32'd3,        32'd5,        32'd15,       33);

      // New DIV, reset during its fifth cycle.
      op = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("abort_busy_before", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_result", result, 32'h0);
      check("abort_zflag", z_flag, 1'b1);
      seen_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done++;
      end
      check("abort_no_done", seen_done, 0);
      check("abort_result_kept", result, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
